i2s_tx_serializer: RTL and testbench

- Downstream consumer of the LR-clock divider output and of the companion bit-clock divider output.
- Accepts stereo PCM frames from the sample source through a valid/ready handshake and buffers one frame.
- Serialises the frame onto the codec DACDAT line in standard I2S format: MSB first, one BCLK after each LRCK edge, LRCK low = left.
- Runs entirely in the 50 MHz clk_in domain. BCLK and LRCK are treated as sampled level inputs.

---
 rtl/i2s_tx_serializer.sv | 150 +++++++++++++++
 tb/tb_i2s_tx_serializer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: buffers one stereo frame and shifts it MSB-first onto DACDAT.
// Optional build macro UNDERRUN_REPEAT_EN: on underrun, repeat the previous frame instead of sending zeros.
module i2s_tx_serializer #(
  parameter int DATA_W = 16,
  parameter int SLOTS  = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              bclk_in,
  input  logic              lrck_in,
  input  logic [DATA_W-1:0] left_in,
  input  logic [DATA_W-1:0] right_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              sdata_out,
  output logic              underrun,
  output logic              frame_start
);

  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [SW-1:0] SLOT_MAX = SW'(SLOTS - 1);
  localparam logic [SW-1:0] ONE      = SW'(1);
  localparam logic [SW:0]   DW_C     = (SW + 1)'(DATA_W);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic              bclk_q;
  logic              lrck_q;
  logic [SW-1:0]     slot, slot_nxt;
  logic              hold_full, hold_full_nxt;
  logic [DATA_W-1:0] hold_left, hold_right;
  logic [DATA_W-1:0] act_left, act_right;
  logic [DATA_W-1:0] act_left_nxt, act_right_nxt;
  logic [DATA_W-1:0] cur_word, shifted;
  logic              sdata_nxt, underrun_nxt, frame_start_nxt;
  logic              boundary, lrck_edge, lrck_fall, accept, load;

  // Handshake: a frame moves into the holding buffer on any clk_in cycle where
  // sample_valid and sample_ready are both high; sample_ready is a register, so
  // the source may hold valid high and there is no valid-to-ready path.
  assign boundary  = bclk_q & ~bclk_in;
  assign lrck_edge = boundary & (lrck_in != lrck_q);
  assign lrck_fall = lrck_edge & ~lrck_in;
  assign accept    = sample_valid & sample_ready;

  // Frame control: leaving IDLE and every later LRCK fall both load a frame.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (lrck_fall) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (lrck_fall) load = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    slot_nxt = slot;
    if (boundary) begin
      if (lrck_edge) slot_nxt = '0;
      else if (slot != SLOT_MAX) slot_nxt = slot + ONE;
    end
  end

  // Holding buffer and active words; the load sees the buffer before any same-cycle accept.
  always_comb begin
    act_left_nxt    = act_left;
    act_right_nxt   = act_right;
    hold_full_nxt   = hold_full;
    underrun_nxt    = 1'b0;
    frame_start_nxt = load;
    if (load) begin
      if (hold_full) begin
        act_left_nxt  = hold_left;
        act_right_nxt = hold_right;
        hold_full_nxt = 1'b0;
      end else begin
        underrun_nxt = 1'b1;
`ifdef UNDERRUN_REPEAT_EN
        act_left_nxt  = act_left;
        act_right_nxt = act_right;
`else
        act_left_nxt  = '0;
        act_right_nxt = '0;
`endif
      end
    end
    if (accept) hold_full_nxt = 1'b1;
  end

  // Slot 0 finishes the previous channel's LSB, so the MSB lands one BCLK after the LRCK edge.
  always_comb begin
    cur_word  = lrck_in ? act_right : act_left;
    shifted   = cur_word << (slot_nxt - ONE);
    sdata_nxt = sdata_out;
    if (boundary) begin
      if (state_nxt != RUN) sdata_nxt = 1'b0;
      else if (slot_nxt == '0) sdata_nxt = lrck_in ? act_left[0] : act_right[0];
      else if ({1'b0, slot_nxt} < DW_C) sdata_nxt = shifted[DATA_W-1];
      else sdata_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bclk_q       <= 1'b0;
      lrck_q       <= 1'b0;
      slot         <= '0;
      hold_full    <= 1'b0;
      hold_left    <= '0;
      hold_right   <= '0;
      act_left     <= '0;
      act_right    <= '0;
      sample_ready <= 1'b1;
      sdata_out    <= 1'b0;
      underrun     <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      state     <= state_nxt;
      bclk_q    <= bclk_in;
      if (boundary) lrck_q <= lrck_in;
      slot      <= slot_nxt;
      hold_full <= hold_full_nxt;
      if (accept) begin
        hold_left  <= left_in;
        hold_right <= right_in;
      end
      act_left     <= act_left_nxt;
      act_right    <= act_right_nxt;
      sample_ready <= ~hold_full_nxt;
      sdata_out    <= sdata_nxt;
      underrun     <= underrun_nxt;
      frame_start  <= frame_start_nxt;
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: bench-generated BCLK (clk/4) and LRCK (clk/128),
// serial words reassembled and compared against an expected queue.
module tb_i2s_tx_serializer;

  localparam int W = 16;

  logic         clk_in = 1'b0;
  logic         rst = 1'b0;
  logic         bclk_in = 1'b0;
  logic         lrck_in = 1'b0;
  logic [W-1:0] left_in = '0;
  logic [W-1:0] right_in = '0;
  logic         sample_valid = 1'b0;
  logic         sample_ready, sdata_out, underrun, frame_start;

  i2s_tx_serializer #(.DATA_W(W), .SLOTS(16)) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .bclk_in      (bclk_in),
    .lrck_in      (lrck_in),
    .left_in      (left_in),
    .right_in     (right_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sdata_out    (sdata_out),
    .underrun     (underrun),
    .frame_start  (frame_start)
  );

  // Clock / reset block
  always #10 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard and source model
  logic [W-1:0] exp_q[$];
  logic [6:0]   cnt = 7'd100;
  logic [W-1:0] cur_bits = '0;
  logic [W-1:0] m_l = '0, m_r = '0, m_last_l = '0, m_last_r = '0;
  logic [W-1:0] pend_l = '0, pend_r = '0, ctr = '0;
  logic         m_full = 1'b0, armed = 1'b0, collecting = 1'b0;
  logic         rdy_prev = 1'b1, prev_sd = 1'b0, was_fall = 1'b0;
  logic         pend = 1'b0, sim_arm = 1'b0;
  int           src_mode = 0;
  int           acc_in_frame = 0, ur_seen = 0, ur0 = 0;
  int           timing_err = 0, idle_err = 0, pulse_err = 0, trk_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_model();
    check("frame_start", {31'd0, frame_start}, 32'd1);
    check("underrun", {31'd0, underrun}, {31'd0, !m_full});
    if (m_full) begin
      exp_q.push_back(m_l);
      exp_q.push_back(m_r);
      m_last_l = m_l;
      m_last_r = m_r;
    end else begin
`ifdef UNDERRUN_REPEAT_EN
      exp_q.push_back(m_last_l);
      exp_q.push_back(m_last_r);
`else
      exp_q.push_back('0);
      exp_q.push_back('0);
`endif
    end
    m_full = 1'b0;
    if (src_mode == 1) begin
      check("acc_per_frame", acc_in_frame, 32'd1);
      check("ready_rise", {31'd0, sample_ready}, 32'd1);
    end
    acc_in_frame = 0;
  endtask

  // Driver: one clk_in cycle; observes at the falling edge, then drives the next inputs.
  task automatic step();
    logic [6:0]  c;
    logic        acc, boundary;
    logic [31:0] exp_w;
    string       tag;
    @(negedge clk_in);
    c        = cnt;
    was_fall = 1'b0;
    if (rst) begin
      m_full = 1'b0; m_last_l = '0; m_last_r = '0;
      armed = 1'b0; collecting = 1'b0; prev_sd = 1'b0;
      exp_q.delete();
    end else begin
      boundary = (c[1:0] == 2'd0);
      was_fall = (c == 7'd0);
      acc      = sample_valid && rdy_prev;
      if (sdata_out !== prev_sd && !boundary) timing_err++;
      prev_sd = sdata_out;
      if (underrun) ur_seen++;
      if (was_fall) armed = 1'b1;
      if (!armed) begin
        if (sdata_out !== 1'b0) idle_err++;
      end else if (boundary) begin
        if (c[5:2] != 4'd0) begin
          cur_bits[W - int'(c[5:2])] = sdata_out;
        end else begin
          if (collecting) begin
            cur_bits[0] = sdata_out;
            exp_w = (exp_q.size() > 0) ? {16'd0, exp_q.pop_front()} : 32'h1_0000;
            tag = c[6] ? "word_left" : "word_right";
            check(tag, {16'd0, cur_bits}, exp_w);
          end
          collecting = 1'b1;
          cur_bits = '0;
        end
      end
      if (was_fall) load_model();
      else if (underrun || frame_start) pulse_err++;
      if (acc) begin
        m_full = 1'b1;
        m_l = left_in;
        m_r = right_in;
        acc_in_frame++;
        if (src_mode == 1) begin
          check("ready_drop", {31'd0, sample_ready}, 32'd0);
          ctr = ctr + 16'd1;
        end
      end
      if (sample_ready !== !m_full) trk_err++;
    end
    rdy_prev = sample_ready;
    cnt     = cnt + 7'd1;
    bclk_in = cnt[1];
    lrck_in = cnt[6];
    sample_valid = 1'b0;
    if (src_mode == 1) begin
      sample_valid = 1'b1;
      left_in  = 16'h1000 + ctr;
      right_in = 16'h2000 + ctr;
    end else if (sim_arm && cnt == 7'd0) begin
      sample_valid = 1'b1;
      left_in  = 16'h8001;
      right_in = 16'h7FFE;
      sim_arm  = 1'b0;
    end else if (pend && sample_ready && !rst) begin
      sample_valid = 1'b1;
      left_in  = pend_l;
      right_in = pend_r;
      pend     = 1'b0;
    end
  endtask

  task automatic run_falls(input int n);
    int k = 0;
    int budget = n * 128 + 16;
    while (k < n && budget > 0) begin
      step();
      if (was_fall) k++;
      budget--;
    end
    if (k < n) check("fall_timeout", k, n);
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", {31'd0, sample_ready}, 32'd1);
    check("rst_sdata", {31'd0, sdata_out}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_frame_start", {31'd0, frame_start}, 32'd0);
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (3) step();
    check_reset_outputs();
    rst = 1'b0;

    // One frame offered before the first LRCK fall
    pend_l = 16'hA5C3; pend_r = 16'h3C5A; pend = 1'b1;
    run_falls(1);
    check("first_underrun", ur_seen, 32'd0);

    // Three frames with no source data
    ur0 = ur_seen;
    run_falls(3);
    check("underrun_3frames", ur_seen - ur0, 32'd3);

    // Source holding valid high
    src_mode = 1;
    run_falls(4);
    src_mode = 0;
    run_falls(1);

    // Offer lands on the frame-start cycle with an empty buffer
    sim_arm = 1'b1;
    ur0 = ur_seen;
    run_falls(1);
    check("sim_underrun", ur_seen - ur0, 32'd1);
    run_falls(1);

    // Reset in the middle of the right half (0x7FFE bit 13 on the line)
    while (cnt != 7'd80) step();
    check("pre_rst_sdata", {31'd0, sdata_out}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    repeat (3) step();
    rst = 1'b0;
    pend_l = 16'h1357; pend_r = 16'hFDB9; pend = 1'b1;
    ur0 = ur_seen;
    run_falls(2);
    check("post_rst_underrun", ur_seen - ur0, 32'd1);

    // Final report
    check("exp_q_left", exp_q.size(), 32'd2);
    check("timing_err", timing_err, 32'd0);
    check("idle_err", idle_err, 32'd0);
    check("pulse_err", pulse_err, 32'd0);
    check("ready_track_err", trk_err, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
